// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES core scheduler.
//   AES_BLK_W  : width of one AES block (plaintext, key, ciphertext)
//   sched_state_e : scheduler FSM state encoding
//   id_width() : requester-index width for a given requester count
package aes_sched_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } sched_state_e;

   // A single requester still needs one index bit so port widths stay legal.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr+1 (wrapping at NUM_REQ) for the first asserted
// request. The pointer register is owned by the caller.
//   req       in   NUM_REQ  request vector
//   ptr       in   ID_W     index of the last winner
//   grant     out  NUM_REQ  one-hot grant, zero when no request
//   grant_id  out  ID_W     encoded index of the winner
//   grant_vld out  1        at least one request is asserted
module aes_rr_arbiter
   import aes_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_vld
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_vld = 1'b0;
      idx       = 0;
      // Offset 1 is the requester just after the last winner, offset
      // NUM_REQ wraps back to the last winner itself (lowest priority).
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_vld && req[idx]) begin
            grant_vld  = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES_top encryption core among NUM_REQ requesters.
// A round-robin grant captures one requester's plaintext/key, the core is
// enabled until it reports valid (or a timeout expires), and the result is
// returned on a single tagged response channel.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for any req_valid; grant issued combinationally
//   RUN   | core_en high, waiting for core valid or timeout
//   RESP  | rsp_valid high, holding response until rsp_ready
//   GAP   | core_en low for GAP_CYCLES cycles so the core can re-arm
//
// Ports:
//   AES_clk, AES_rst            clock, synchronous active-high reset
//   req_valid/ready/data/key    per-requester job channel (packed 128b slots)
//   core_en/data_in/key_in      drive AES_top AES_en/AES_data_in/AES_key_in
//   core_data_out(_valid)       result from AES_top
//   rsp_valid/ready/data/id/err tagged response channel
//   busy                        FSM is not in IDLE
//   err_count                   saturating count of timed-out jobs
module aes_core_scheduler
   import aes_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = id_width(NUM_REQ),
   parameter int TIMEOUT    = 255,
   parameter int GAP_CYCLES = 2
) (
   input  logic                         AES_clk,
   input  logic                         AES_rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
   input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
   output logic                         core_en,
   output logic [AES_BLK_W-1:0]         core_data_in,
   output logic [AES_BLK_W-1:0]         core_key_in,
   input  logic [AES_BLK_W-1:0]         core_data_out,
   input  logic                         core_data_out_valid,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [AES_BLK_W-1:0]         rsp_data,
   output logic [ID_W-1:0]              rsp_id,
   output logic                         rsp_err,
   output logic                         busy,
   output logic [7:0]                   err_count
);

   // One down-counter serves both the RUN timeout and the GAP length.
   localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TMR_RUN_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

   sched_state_e state;
   sched_state_e state_nxt;

   logic [ID_W-1:0]      rr_ptr;
   logic [TMR_W-1:0]     tmr;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_id;
   logic                 grant_vld;
   logic [AES_BLK_W-1:0] sel_data;
   logic [AES_BLK_W-1:0] sel_key;

   logic run_first;
   logic do_grant;
   logic do_done;
   logic do_timeout;
   logic leave_resp;

   aes_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_vld (grant_vld)
   );

   always_comb begin
      sel_data = '0;
      sel_key  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_data = req_data[i*AES_BLK_W +: AES_BLK_W];
            sel_key  = req_key[i*AES_BLK_W +: AES_BLK_W];
         end
      end
   end

   // The timer is loaded with TIMEOUT-1 on grant, so it still holds the
   // load value during the first RUN cycle; that is where a stale valid
   // left over from the previous job gets masked.
   assign run_first = (tmr == TMR_RUN_LOAD);

   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_done    = 1'b0;
      do_timeout = 1'b0;
      leave_resp = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld && !AES_rst) begin
               do_grant  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // A valid in the terminal cycle still counts as a result.
            if (core_data_out_valid && !run_first) begin
               do_done   = 1'b1;
               state_nxt = RESP;
            end else if (tmr == '0) begin
               do_timeout = 1'b1;
               state_nxt  = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               leave_resp = 1'b1;
               state_nxt  = GAP;
            end
         end
         GAP: begin
            if (tmr == '0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         rr_ptr       <= ID_W'(NUM_REQ - 1);
         tmr          <= '0;
         core_data_in <= '0;
         core_key_in  <= '0;
         rsp_data     <= '0;
         rsp_id       <= '0;
         rsp_err      <= 1'b0;
         err_count    <= '0;
      end else begin
         if (do_grant) begin
            core_data_in <= sel_data;
            core_key_in  <= sel_key;
            rsp_id       <= grant_id;
            rr_ptr       <= grant_id;
            tmr          <= TMR_RUN_LOAD;
         end else if (leave_resp) begin
            tmr <= TMR_GAP_LOAD;
         end else if ((state == RUN || state == GAP) && tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
         end

         if (do_done) begin
            rsp_data <= core_data_out;
            rsp_err  <= 1'b0;
         end else if (do_timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end
      end
   end

   // Grant is gated by reset so nothing is offered while reset is held.
   assign req_ready = (state == IDLE && !AES_rst) ? grant : '0;
   assign core_en   = (state == RUN);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_core_scheduler.sv
`timescale 1ns/1ps
module tb_aes_core_scheduler;
   import aes_sched_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int ID_W        = 2;
   localparam int TIMEOUT     = 255;
   localparam int GAP_CYCLES  = 2;
   localparam int CORE_LAT    = 12;
   localparam int GRANT_BOUND = 64;
   localparam int RSP_BOUND   = 400;
   localparam int TO_JOBS     = 258;

   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] STALE  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

   logic                         AES_clk = 1'b0;
   logic                         AES_rst = 1'b1;
   logic [NUM_REQ-1:0]           req_valid = '0;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*AES_BLK_W-1:0] req_data = '0;
   logic [NUM_REQ*AES_BLK_W-1:0] req_key = '0;
   logic                         core_en;
   logic [AES_BLK_W-1:0]         core_data_in;
   logic [AES_BLK_W-1:0]         core_key_in;
   logic [AES_BLK_W-1:0]         core_data_out;
   logic                         core_data_out_valid;
   logic                         rsp_valid;
   logic                         rsp_ready = 1'b0;
   logic [AES_BLK_W-1:0]         rsp_data;
   logic [ID_W-1:0]              rsp_id;
   logic                         rsp_err;
   logic                         busy;
   logic [7:0]                   err_count;

   int checks = 0;
   int failures = 0;
   int core_mode = 0;   // 0 normal, 1 silent, 2 stale valid, 3 valid at timeout cycle
   int en_cnt = 0;
   int model_last = NUM_REQ - 1;
   int model_err = 0;

   always #5 AES_clk = ~AES_clk;

   aes_core_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W),
      .TIMEOUT    (TIMEOUT),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .AES_clk             (AES_clk),
      .AES_rst             (AES_rst),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_data            (req_data),
      .req_key             (req_key),
      .core_en             (core_en),
      .core_data_in        (core_data_in),
      .core_key_in         (core_key_in),
      .core_data_out       (core_data_out),
      .core_data_out_valid (core_data_out_valid),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_data            (rsp_data),
      .rsp_id              (rsp_id),
      .rsp_err             (rsp_err),
      .busy                (busy),
      .err_count           (err_count)
   );

   // Core stand-in: FIPS-197 answers for the two known vectors, a fixed
   // reversible scramble for anything else.
   function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
      if (d == PT_C1 && k == KEY_C1) return CT_C1;
      if (d == PT_B && k == KEY_B) return CT_B;
      return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
   endfunction

   function automatic logic [127:0] slot(input logic [NUM_REQ*AES_BLK_W-1:0] v, input int i);
      return v[i*AES_BLK_W +: AES_BLK_W];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference arbitration rule: first asserted index after the last winner.
   function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // en_cnt = number of cycles core_en has been high before the current one
   always @(posedge AES_clk) en_cnt <= core_en ? en_cnt + 1 : 0;

   always_comb begin
      core_data_out       = cipher(core_data_in, core_key_in);
      core_data_out_valid = 1'b0;
      case (core_mode)
         0: core_data_out_valid = core_en && (en_cnt == CORE_LAT);
         2: begin
            core_data_out_valid = 1'b1;
            if (en_cnt == 0) core_data_out = STALE;
         end
         3: core_data_out_valid = core_en && (en_cnt == TIMEOUT - 1);
         default: core_data_out_valid = 1'b0;
      endcase
   end

   // Returns at the negedge of RUN cycle 1 (one edge after the grant was seen).
   task automatic wait_grant(output int gid, output bit ok, output logic [NUM_REQ-1:0] rdy);
      ok = 1'b0;
      gid = -1;
      rdy = '0;
      for (int i = 0; i < GRANT_BOUND && !ok; i++) begin
         #1;
         if (req_ready != '0) begin
            ok  = 1'b1;
            rdy = req_ready;
            gid = onehot_idx(req_ready);
         end
         @(negedge AES_clk);
      end
   endtask

   // Counts core_en-high cycles until rsp_valid appears; ends at a RESP negedge.
   task automatic wait_rsp(output int en_cyc, output bit ok);
      en_cyc = 0;
      ok = 1'b0;
      for (int i = 0; i < RSP_BOUND && !ok; i++) begin
         if (rsp_valid) ok = 1'b1;
         else begin
            if (core_en) en_cyc++;
            @(negedge AES_clk);
         end
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(negedge AES_clk);
      rsp_ready = 1'b0;
      repeat (GAP_CYCLES) @(negedge AES_clk);
   endtask

   task automatic do_reset();
      AES_rst = 1'b1;
      repeat (2) @(negedge AES_clk);
      AES_rst = 1'b0;
      model_last = NUM_REQ - 1;
      model_err = 0;
   endtask

   task automatic test_reset();
      AES_rst = 1'b1;
      req_valid = '1;
      repeat (3) @(negedge AES_clk);
      #1;
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      checks++; if (core_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_ctrl got en=%b busy=%b rsp_valid=%b exp=0", core_en, busy, rsp_valid); end
      checks++; if (core_data_in !== '0 || core_key_in !== '0) begin failures++; $display("FAIL reset_core_bus got data=%h key=%h exp=0", core_data_in, core_key_in); end
      checks++; if (rsp_data !== '0 || rsp_id !== '0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp got data=%h id=%0d err=%b exp=0", rsp_data, rsp_id, rsp_err); end
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
      req_valid = '0;
      AES_rst = 1'b0;
      model_last = NUM_REQ - 1;
      model_err = 0;
      @(negedge AES_clk);
   endtask

   task automatic test_single();
      logic [127:0] pt [2];
      logic [127:0] ky [2];
      logic [127:0] ct [2];
      int who [2];
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      pt[0] = PT_C1; ky[0] = KEY_C1; ct[0] = CT_C1; who[0] = 0;
      pt[1] = PT_B;  ky[1] = KEY_B;  ct[1] = CT_B;  who[1] = 2;
      for (int v = 0; v < 2; v++) begin
         req_data[who[v]*AES_BLK_W +: AES_BLK_W] = pt[v];
         req_key[who[v]*AES_BLK_W +: AES_BLK_W]  = ky[v];
         req_valid = '0;
         req_valid[who[v]] = 1'b1;
         exp_id = rr_pick(req_valid, model_last);
         wait_grant(gid, ok, rdy);
         model_last = exp_id;
         req_valid = '0;
         checks++; if (!ok || gid != exp_id) begin failures++; $display("FAIL single_grant v=%0d got=%0d ok=%0d exp=%0d", v, gid, ok, exp_id); end
         checks++; if (core_data_in !== pt[v] || core_key_in !== ky[v]) begin failures++; $display("FAIL single_capture v=%0d got=%h/%h exp=%h/%h", v, core_data_in, core_key_in, pt[v], ky[v]); end
         wait_rsp(en_cyc, ok);
         checks++; if (!ok) begin failures++; $display("FAIL single_rsp_timeout v=%0d got=no rsp exp=rsp_valid", v); end
         checks++; if (en_cyc != CORE_LAT + 1) begin failures++; $display("FAIL single_en_len v=%0d got=%0d exp=%0d", v, en_cyc, CORE_LAT + 1); end
         checks++; if (rsp_data !== ct[v]) begin failures++; $display("FAIL single_data v=%0d got=%h exp=%h", v, rsp_data, ct[v]); end
         checks++; if (rsp_id !== ID_W'(exp_id) || rsp_err !== 1'b0) begin failures++; $display("FAIL single_tag v=%0d got id=%0d err=%b exp id=%0d err=0", v, rsp_id, rsp_err, exp_id); end
         rsp_ready = 1'b1;
         @(negedge AES_clk);
         rsp_ready = 1'b0;
         checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || core_en !== 1'b0) begin failures++; $display("FAIL single_gap1 got rsp_valid=%b busy=%b en=%b exp 0/1/0", rsp_valid, busy, core_en); end
         @(negedge AES_clk);
         checks++; if (busy !== 1'b1 || core_en !== 1'b0) begin failures++; $display("FAIL single_gap2 got busy=%b en=%b exp 1/0", busy, core_en); end
         @(negedge AES_clk);
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got busy=%b exp 0", busy); end
      end
   endtask

   task automatic test_round_robin();
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      logic [127:0] exp_ct;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[i*AES_BLK_W +: AES_BLK_W] = rand128();
         req_key[i*AES_BLK_W +: AES_BLK_W]  = rand128();
      end
      req_valid = '1;
      for (int j = 0; j < 8; j++) begin
         exp_id = rr_pick(req_valid, model_last);
         exp_ct = cipher(slot(req_data, exp_id), slot(req_key, exp_id));
         wait_grant(gid, ok, rdy);
         model_last = exp_id;
         checks++; if (!ok || gid != exp_id || !$onehot(rdy)) begin failures++; $display("FAIL rr_grant job=%0d got=%0d rdy=%b exp=%0d", j, gid, rdy, exp_id); end
         if (exp_id >= 0) begin
            req_data[exp_id*AES_BLK_W +: AES_BLK_W] = rand128();
            req_key[exp_id*AES_BLK_W +: AES_BLK_W]  = rand128();
         end
         wait_rsp(en_cyc, ok);
         checks++; if (!ok || rsp_id !== ID_W'(exp_id) || rsp_data !== exp_ct || rsp_err !== 1'b0) begin failures++; $display("FAIL rr_rsp job=%0d got id=%0d data=%h err=%b exp id=%0d data=%h", j, rsp_id, rsp_data, rsp_err, exp_id, exp_ct); end
         release_rsp();
      end
      req_valid = '0;
   endtask

   task automatic test_random();
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      logic [127:0] exp_ct;
      for (int j = 0; j < 12; j++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*AES_BLK_W +: AES_BLK_W] = rand128();
            req_key[i*AES_BLK_W +: AES_BLK_W]  = rand128();
         end
         req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         exp_id = rr_pick(req_valid, model_last);
         exp_ct = cipher(slot(req_data, exp_id), slot(req_key, exp_id));
         wait_grant(gid, ok, rdy);
         model_last = exp_id;
         req_valid = '0;
         checks++; if (!ok || gid != exp_id) begin failures++; $display("FAIL rand_grant job=%0d got=%0d exp=%0d", j, gid, exp_id); end
         wait_rsp(en_cyc, ok);
         checks++; if (!ok || rsp_id !== ID_W'(exp_id) || rsp_data !== exp_ct || rsp_err !== 1'b0) begin failures++; $display("FAIL rand_rsp job=%0d got id=%0d data=%h err=%b exp id=%0d data=%h", j, rsp_id, rsp_data, rsp_err, exp_id, exp_ct); end
         release_rsp();
      end
   endtask

   task automatic test_backpressure();
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      logic [127:0] exp_ct;
      req_data[1*AES_BLK_W +: AES_BLK_W] = rand128();
      req_key[1*AES_BLK_W +: AES_BLK_W]  = rand128();
      req_valid = 4'b0010;
      exp_id = rr_pick(req_valid, model_last);
      exp_ct = cipher(slot(req_data, 1), slot(req_key, 1));
      wait_grant(gid, ok, rdy);
      model_last = exp_id;
      req_valid = '0;
      wait_rsp(en_cyc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_rsp_timeout got=no rsp exp=rsp_valid"); end
      req_valid = '1;
      for (int c = 0; c < 20; c++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_ct || rsp_id !== ID_W'(exp_id) || rsp_err !== 1'b0 || req_ready !== '0 || core_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got v=%b data=%h id=%0d err=%b rdy=%b en=%b exp v=1 data=%h id=%0d err=0 rdy=0 en=0", c, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready, core_en, exp_ct, exp_id);
         end
         @(negedge AES_clk);
      end
      // Requester 3 asserts during GAP and withdraws before IDLE: no grant for it.
      rsp_ready = 1'b1;
      req_valid = 4'b1000;
      @(negedge AES_clk);
      rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== '0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_gap got rdy=%b rsp_valid=%b exp 0/0", req_ready, rsp_valid); end
      @(negedge AES_clk);
      req_valid = 4'b0001;
      req_data[0 +: AES_BLK_W] = rand128();
      exp_id = rr_pick(req_valid, model_last);
      exp_ct = cipher(slot(req_data, 0), slot(req_key, 0));
      wait_grant(gid, ok, rdy);
      model_last = exp_id;
      req_valid = '0;
      checks++; if (!ok || gid != 0) begin failures++; $display("FAIL drop_grant got=%0d exp=0", gid); end
      wait_rsp(en_cyc, ok);
      checks++; if (!ok || rsp_data !== exp_ct || rsp_id !== 0) begin failures++; $display("FAIL drop_rsp got id=%0d data=%h exp id=0 data=%h", rsp_id, rsp_data, exp_ct); end
      release_rsp();
   endtask

   task automatic test_stale_collision();
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      logic [127:0] exp_ct;
      for (int m = 2; m <= 3; m++) begin
         core_mode = m;
         req_data[2*AES_BLK_W +: AES_BLK_W] = rand128();
         req_key[2*AES_BLK_W +: AES_BLK_W]  = rand128();
         req_valid = 4'b0100;
         exp_id = rr_pick(req_valid, model_last);
         exp_ct = cipher(slot(req_data, 2), slot(req_key, 2));
         wait_grant(gid, ok, rdy);
         model_last = exp_id;
         req_valid = '0;
         wait_rsp(en_cyc, ok);
         checks++; if (!ok || en_cyc != ((m == 2) ? 2 : TIMEOUT)) begin failures++; $display("FAIL mode%0d_run_len got=%0d ok=%0d exp=%0d", m, en_cyc, ok, (m == 2) ? 2 : TIMEOUT); end
         checks++; if (rsp_data !== exp_ct || rsp_err !== 1'b0) begin failures++; $display("FAIL mode%0d_rsp got data=%h err=%b exp data=%h err=0", m, rsp_data, rsp_err, exp_ct); end
         checks++; if (err_count !== 8'(model_err)) begin failures++; $display("FAIL mode%0d_err_count got=%0d exp=%0d", m, err_count, model_err); end
         release_rsp();
      end
      core_mode = 0;
   endtask

   task automatic test_timeout();
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      core_mode = 1;
      for (int n = 1; n <= TO_JOBS; n++) begin
         req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         exp_id = rr_pick(req_valid, model_last);
         wait_grant(gid, ok, rdy);
         model_last = exp_id;
         req_valid = '0;
         wait_rsp(en_cyc, ok);
         model_err = (model_err < 255) ? model_err + 1 : 255;
         if (n == 1) begin
            checks++; if (!ok || en_cyc != TIMEOUT) begin failures++; $display("FAIL to_run_len got=%0d ok=%0d exp=%0d", en_cyc, ok, TIMEOUT); end
         end
         checks++;
         if (!ok || gid != exp_id || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== ID_W'(exp_id) || err_count !== 8'(model_err)) begin
            failures++;
            $display("FAIL to_job n=%0d got gid=%0d err=%b data=%h id=%0d cnt=%0d exp gid=%0d err=1 data=0 cnt=%0d", n, gid, rsp_err, rsp_data, rsp_id, err_count, exp_id, model_err);
         end
         release_rsp();
      end
      core_mode = 0;
   endtask

   task automatic test_reset_mid_run();
      int gid, en_cyc, exp_id;
      bit ok;
      logic [NUM_REQ-1:0] rdy;
      logic [127:0] exp_ct;
      req_valid = 4'b0100;
      wait_grant(gid, ok, rdy);
      repeat (4) @(negedge AES_clk);
      checks++; if (!ok || core_en !== 1'b1) begin failures++; $display("FAIL midrst_pre got ok=%0d en=%b exp 1/1", ok, core_en); end
      AES_rst = 1'b1;
      @(negedge AES_clk);
      checks++; if (core_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL midrst_post got en=%b v=%b busy=%b cnt=%0d exp 0/0/0/0", core_en, rsp_valid, busy, err_count); end
      AES_rst = 1'b0;
      model_last = NUM_REQ - 1;
      model_err = 0;
      req_valid = '1;
      exp_id = rr_pick(req_valid, model_last);
      exp_ct = cipher(slot(req_data, exp_id), slot(req_key, exp_id));
      wait_grant(gid, ok, rdy);
      model_last = exp_id;
      req_valid = '0;
      checks++; if (!ok || gid != 0 || exp_id != 0) begin failures++; $display("FAIL midrst_grant got=%0d exp=0", gid); end
      wait_rsp(en_cyc, ok);
      checks++; if (!ok || rsp_data !== exp_ct || rsp_id !== 0 || rsp_err !== 1'b0) begin failures++; $display("FAIL midrst_rsp got id=%0d data=%h err=%b exp id=0 data=%h", rsp_id, rsp_data, rsp_err, exp_ct); end
      release_rsp();
   endtask

   initial begin
      #(1_500_000);
      $display("FAIL watchdog got=time limit exp=finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_random();
      test_backpressure();
      test_stale_collision();
      test_timeout();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
